// File: rtl/edge_arb_pkg.sv
// Shared constants and helpers for the edge event arbiter.
package edge_arb_pkg;

  localparam int OVF_CNT_W = 8;

  // Channel-index width, never below one bit.
  function automatic int ch_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or above pointer, wrapping.
// Zero latency; no grant while enable (output slot free) is low.
module rr_arbiter
  import edge_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = ch_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   pointer,
  input  logic              enable,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx,
  output logic              valid
);

  int cand;

  // Scan from the farthest offset down so the nearest requester is the last writer.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    cand      = 0;
    for (int off = NUM_CH - 1; off >= 0; off--) begin
      cand = int'(pointer) + off;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      if (enable && req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        grant_idx   = CH_W'(cand);
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/edge_event_arbiter.sv
// Synchronise, edge-detect and latch per-channel events; drain one per cycle round-robin.
// Event visible SYNC_STAGES+2 edges after input rise; output held while evt_ready is low. Option: EDGE_ARB_OVF_CNT_EN.
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CH_W        = ch_width(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    sig_in,
  input  logic [NUM_CH-1:0]    ch_enable,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [CH_W-1:0]      evt_ch,
  output logic [NUM_CH-1:0]    pending,
  output logic [NUM_CH-1:0]    overflow,
  input  logic                 clr_overflow
`ifdef EDGE_ARB_OVF_CNT_EN
  ,
  output logic [OVF_CNT_W-1:0] ovf_count
`endif
);

  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] prev;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] load;
  logic [NUM_CH-1:0] ovf_set;
  logic [NUM_CH-1:0] pending_next;
  logic [CH_W-1:0]   ptr;
  logic [CH_W-1:0]   grant_idx;
  logic              grant_vld;
  logic              slot_free;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev <= '0;
    end else begin
      sync_q[0] <= sig_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise      = sync_q[SYNC_STAGES-1] & ~prev & ch_enable;
  assign slot_free = !evt_valid || evt_ready;

  // Disabled channels are masked so a flushed event can never be issued.
  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_rr (
    .req       (pending & ch_enable),
    .pointer   (ptr),
    .enable    (slot_free),
    .grant     (load),
    .grant_idx (grant_idx),
    .valid     (grant_vld)
  );

  assign pending_next = ch_enable & (rise | (pending & ~load));
  assign ovf_set      = rise & pending & ~load;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      ptr       <= '0;
      pending   <= '0;
      overflow  <= '0;
    end else begin
      pending  <= pending_next;
      overflow <= (clr_overflow ? '0 : overflow) | ovf_set;
      if (slot_free) begin
        evt_valid <= grant_vld;
        if (grant_vld) begin
          evt_ch <= grant_idx;
          ptr    <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
        end
      end
    end
  end

`ifdef EDGE_ARB_OVF_CNT_EN
  logic [OVF_CNT_W:0] ovf_inc;
  logic [OVF_CNT_W:0] ovf_sum;

  always_comb begin
    ovf_inc = '0;
    for (int i = 0; i < NUM_CH; i++) ovf_inc = ovf_inc + {{OVF_CNT_W{1'b0}}, ovf_set[i]};
  end

  // A clear restarts from zero but still counts this cycle's losses.
  assign ovf_sum = (clr_overflow ? '0 : {1'b0, ovf_count}) + ovf_inc;

  always_ff @(posedge clk) begin
    if (!rst_n) ovf_count <= '0;
    else        ovf_count <= ovf_sum[OVF_CNT_W] ? '1 : ovf_sum[OVF_CNT_W-1:0];
  end
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Scoreboarded bench: delay-line reference model feeds an expected-channel queue; monitor pops on handshakes.
module tb_edge_event_arbiter;
  import edge_arb_pkg::*;

  localparam int N  = 4;
  localparam int SS = 2;
  localparam int CW = ch_width(N);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  sig_in;
  logic [N-1:0]  ch_enable;
  logic          evt_valid;
  logic          evt_ready;
  logic [CW-1:0] evt_ch;
  logic [N-1:0]  pending;
  logic [N-1:0]  overflow;
  logic          clr_overflow;
`ifdef EDGE_ARB_OVF_CNT_EN
  logic [7:0]    ovf_count;
`endif

  always #5 clk = ~clk;

  edge_event_arbiter #(.NUM_CH(N), .SYNC_STAGES(SS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sig_in       (sig_in),
    .ch_enable    (ch_enable),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_ch       (evt_ch),
    .pending      (pending),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
`ifdef EDGE_ARB_OVF_CNT_EN
    ,
    .ovf_count    (ovf_count)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  bit [N-1:0] line [$];
  bit [N-1:0] m_pend, m_ovf;
  bit         m_valid;
  int         m_ptr, m_cnt;
  int         exp_q [$];
  int         acc_cnt;
  int         acc_log [$];

  bit [N-1:0] sl, pv, rise_m, load_m, oset_m;
  int         g, c, inc;

  always @(posedge clk) begin
    if (!rst_n) begin
      line.delete();
      repeat (SS + 1) line.push_back('0);
      m_pend = '0; m_ovf = '0; m_valid = 1'b0; m_ptr = 0; m_cnt = 0;
      exp_q.delete();
    end else begin
      sl     = line[SS-1];
      pv     = line[SS];
      rise_m = sl & ~pv & ch_enable;
      load_m = '0;
      if (!m_valid || evt_ready) begin
        g = -1;
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (g < 0 && m_pend[c] && ch_enable[c]) g = c;
        end
        if (g >= 0) begin
          m_valid   = 1'b1;
          load_m[g] = 1'b1;
          exp_q.push_back(g);
          m_ptr = (g + 1) % N;
        end else begin
          m_valid = 1'b0;
        end
      end
      oset_m = rise_m & m_pend & ~load_m;
      for (int i = 0; i < N; i++) begin
        if (!ch_enable[i])   m_pend[i] = 1'b0;
        else if (rise_m[i])  m_pend[i] = 1'b1;
        else if (load_m[i])  m_pend[i] = 1'b0;
      end
      m_ovf = (clr_overflow ? '0 : m_ovf) | oset_m;
      inc   = $countones(oset_m);
      m_cnt = (clr_overflow ? 0 : m_cnt) + inc;
      if (m_cnt > 255) m_cnt = 255;
      line.push_front(sig_in);
      void'(line.pop_back());
    end
  end

  // Monitor
  always @(negedge clk) begin
    check("evt_valid", evt_valid, m_valid);
    check("pending", pending, m_pend);
    check("overflow", overflow, m_ovf);
`ifdef EDGE_ARB_OVF_CNT_EN
    check("ovf_count", ovf_count, m_cnt);
`endif
    if (evt_valid) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL evt_unexpected: got ch %0d expected none at %0t", evt_ch, $time);
      end else begin
        check("evt_ch", evt_ch, exp_q[0]);
        if (evt_ready && rst_n) begin
          void'(exp_q.pop_front());
          acc_cnt++;
          acc_log.push_back(int'(evt_ch));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int a0;

  initial begin
    rst_n = 1'b0; sig_in = '1; ch_enable = '1; evt_ready = 1'b1; clr_overflow = 1'b0;
    acc_cnt = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", evt_valid, 0);
    check("rst_pending", pending, 0);
    check("rst_overflow", overflow, 0);
    tick(1);
    rst_n = 1'b1;
    tick(10);
    check("post_reset_events", acc_cnt, 4);

    // Single rise on ch2: valid after edge 4 for one cycle
    sig_in = '0;
    tick(6);
    sig_in[2] = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("lat_valid", evt_valid, 1);
    check("lat_ch", evt_ch, 2);
    @(negedge clk);
    check("lat_one_cycle", evt_valid, 0);
    check("lat_pending", pending, 0);

    // All four at once
    sig_in = '0;
    tick(5);
    a0 = acc_cnt;
    sig_in = '1;
    tick(12);
    check("burst_count", acc_cnt - a0, 4);

    // Backpressure with three ch1 pulses
    sig_in = '0;
    tick(5);
    evt_ready = 1'b0;
    repeat (3) begin
      sig_in[1] = 1'b1; tick(3);
      sig_in[1] = 1'b0; tick(3);
    end
    tick(2);
    check("bp_overflow1", overflow[1], 1);
    check("bp_pending1", pending[1], 1);
    check("bp_slot_ch", evt_ch, 1);
    a0 = acc_cnt;
    evt_ready = 1'b1;
    tick(6);
    check("bp_two_events", acc_cnt - a0, 2);

    // Fairness: ch0 granted (pointer -> 1), ch3 pending, ch0 rises again
    sig_in = '0;
    tick(5);
    evt_ready = 1'b0;
    acc_log.delete();
    sig_in[0] = 1'b1; tick(3);
    sig_in[0] = 1'b0; sig_in[3] = 1'b1; tick(3);
    sig_in[0] = 1'b1; tick(3);
    sig_in[0] = 1'b0; tick(3);
    evt_ready = 1'b1;
    tick(6);
    check("fair_len", acc_log.size(), 3);
    if (acc_log.size() == 3) begin
      check("fair_first", acc_log[0], 0);
      check("fair_ch3_before_ch0", acc_log[1], 3);
    end

    // Flush by ch_enable, then clear colliding with a new overflow
    sig_in = '0;
    tick(5);
    evt_ready = 1'b0;
    sig_in[1] = 1'b1; tick(3);
    sig_in[2] = 1'b1; tick(4);
    check("flush_pre", pending[2], 1);
    ch_enable[2] = 1'b0;
    tick(1);
    @(negedge clk);
    check("flush_post", pending[2], 0);
    ch_enable = '1;
    tick(1);
    sig_in[0] = 1'b1; tick(3);
    sig_in[0] = 1'b0; tick(3);
    sig_in[0] = 1'b1;
    tick(2);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    check("clr_vs_set", overflow, 4'b0001);
    evt_ready = 1'b1;
    sig_in = '0;
    tick(8);

    // Randomised traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(3) == 0) sig_in[i] = ~sig_in[i];
        ch_enable[i] = ($urandom_range(31) != 0);
      end
      evt_ready    = ($urandom_range(3) != 0);
      clr_overflow = ($urandom_range(15) == 0);
      rst_n        = ($urandom_range(499) != 0);
      tick(1);
    end

    rst_n = 1'b1; ch_enable = '1; evt_ready = 1'b1; clr_overflow = 1'b0;
    tick(20);
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
